apf_video_encoder: RTL

Final video stage between the scanline filler and the Pocket scaler pins. Passes sync, DE and RGB through with fixed one-cycle latency and inserts one end-of-line command word per line in DE-low time, carrying the scaler slot for the current frame. The slot is latched from the filler's `snap_index` once per frame, so the scaler never changes mode mid-frame. Optionally measures active width and height per frame for debug and bridge readout.

---
 rtl/apf_video_encoder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/apf_video_encoder.sv
// apf_video_encoder
//   Final video stage in front of the Pocket scaler pins. Syncs, DE and RGB
//   pass through with exactly one cycle of latency. Once per line, in DE-low
//   time, one command word is inserted that carries the scaler slot for the
//   current frame. The slot is latched from snap_index on vsync_in only, so
//   the scaler never changes mode mid-frame.
//
//   Optional feature: define APF_VIDEO_ENCODER_MEASURE_EN to build the
//   per-frame width/height measurement. Without it the frame_* outputs are
//   tied to 0.
//
// Ports
//   clk, reset          pixel clock, synchronous active-high reset
//   hsync_in, vsync_in  syncs from the scanline filler (vsync is one cycle)
//   de_in, rgb_in       data enable and pixel data (rgb_in is 0 when DE low)
//   snap_index          requested scaler slot
//   vid_hs/vs/de/rgb    registered video to the scaler; vid_rgb also
//                       carries the command word
//   frame_width/height  active width/height of the last completed frame
//   frame_valid         last frame was rectangular and non-empty
module apf_video_encoder #(
   parameter int SLOT_BITS = 3,
   parameter int CMD_DELAY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        de_in,
   input  logic [23:0] rgb_in,
   input  logic [7:0]  snap_index,
   output logic        vid_hs,
   output logic        vid_vs,
   output logic        vid_de,
   output logic [23:0] vid_rgb,
   output logic [9:0]  frame_width,
   output logic [8:0]  frame_height,
   output logic        frame_valid
);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_WAIT, S_CMD} state_t;

   localparam int SLOT_MAX = (1 << SLOT_BITS) - 1;

   // Requests beyond the slot field clamp to the highest slot.
   function automatic logic [SLOT_BITS-1:0] sat_slot(input logic [7:0] idx);
      logic [9:0] w_idx;
      w_idx = {2'b00, idx};
      if (int'(idx) > SLOT_MAX) return '1;
      return w_idx[SLOT_BITS-1:0];
   endfunction

   function automatic logic [23:0] cmd_word(input logic [SLOT_BITS-1:0] slot);
      return {11'b0, 10'(slot), 3'b001};
   endfunction

   state_t               r_state;
   logic [2:0]           r_cnt;
   logic                 r_de_prev;
   logic [SLOT_BITS-1:0] r_frame_slot;
   logic [SLOT_BITS-1:0] r_cmd_slot;

   logic                 w_de_fall;
   logic                 w_fire;
   logic [SLOT_BITS-1:0] w_fire_slot;

   assign w_de_fall = ~de_in & r_de_prev;

   // The command word is registered on the edge that enters CMD, so the CMD
   // state and the command on vid_rgb coincide. With no delay it fires on
   // the DE fall itself; otherwise when WAIT expires, regardless of de_in
   // (a pixel arriving that cycle is dropped).
   assign w_fire = ((r_state == S_ACTIVE) && w_de_fall && (CMD_DELAY == 0)) ||
                   ((r_state == S_WAIT) && (r_cnt == 3'd0));

   // On a zero-delay fire cmd_slot is being captured this very cycle.
   assign w_fire_slot = (r_state == S_WAIT) ? r_cmd_slot : r_frame_slot;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_de_prev    <= 1'b0;
         r_frame_slot <= '0;
         r_cmd_slot   <= '0;
         vid_hs       <= 1'b0;
         vid_vs       <= 1'b0;
         vid_de       <= 1'b0;
         vid_rgb      <= '0;
      end else begin
         r_de_prev <= de_in;
         // cmd_slot below reads the pre-update slot, so a vsync on a DE fall
         // still sends the old slot for that line.
         if (vsync_in) r_frame_slot <= sat_slot(snap_index);

         vid_hs <= hsync_in;
         vid_vs <= vsync_in;
         if (w_fire) begin
            vid_de  <= 1'b0;
            vid_rgb <= cmd_word(w_fire_slot);
         end else begin
            vid_de  <= de_in;
            vid_rgb <= de_in ? rgb_in : 24'h0;
         end

         case (r_state)
            S_IDLE: if (de_in) r_state <= S_ACTIVE;
            S_ACTIVE: begin
               if (w_de_fall) begin
                  r_cmd_slot <= r_frame_slot;
                  if (CMD_DELAY == 0) begin
                     r_state <= S_CMD;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= 3'(CMD_DELAY - 1);
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == 3'd0)  r_state <= S_CMD;
               else if (de_in)     r_state <= S_ACTIVE;
               else                r_cnt   <= r_cnt - 3'd1;
            end
            S_CMD:   r_state <= de_in ? S_ACTIVE : S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef APF_VIDEO_ENCODER_MEASURE_EN
   logic [9:0] r_pix_cnt;
   logic [9:0] r_ref_width;
   logic [8:0] r_line_cnt;
   logic       r_mismatch;

   logic [9:0] w_ref_nxt;
   logic [8:0] w_line_nxt;
   logic       w_mis_nxt;

   // Line bookkeeping including a line ending this cycle, so a vsync that
   // lands on the DE fall still counts that line.
   always_comb begin
      w_ref_nxt  = r_ref_width;
      w_line_nxt = r_line_cnt;
      w_mis_nxt  = r_mismatch;
      if (w_de_fall) begin
         if (r_line_cnt != 9'd511)             w_line_nxt = r_line_cnt + 9'd1;
         if (r_line_cnt == 9'd0)               w_ref_nxt  = r_pix_cnt;
         else if (r_pix_cnt != r_ref_width)    w_mis_nxt  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pix_cnt    <= '0;
         r_ref_width  <= '0;
         r_line_cnt   <= '0;
         r_mismatch   <= 1'b0;
         frame_width  <= '0;
         frame_height <= '0;
         frame_valid  <= 1'b0;
      end else begin
         if (w_de_fall)                          r_pix_cnt <= '0;
         else if (de_in && r_pix_cnt != 10'd1023) r_pix_cnt <= r_pix_cnt + 10'd1;

         if (vsync_in) begin
            frame_width  <= w_ref_nxt;
            frame_height <= w_line_nxt;
            frame_valid  <= ~w_mis_nxt && (w_line_nxt != 9'd0);
            r_line_cnt   <= '0;
            r_ref_width  <= '0;
            r_mismatch   <= 1'b0;
         end else begin
            r_line_cnt   <= w_line_nxt;
            r_ref_width  <= w_ref_nxt;
            r_mismatch   <= w_mis_nxt;
         end
      end
   end
`else
   assign frame_width  = '0;
   assign frame_height = '0;
   assign frame_valid  = 1'b0;
`endif

endmodule
